// File: rtl/regfile_rat_if.sv
// Decode/dispatch/ROB bundle for regfile_rat.
// master drives IND/DP-stall/ROB; slave is the register file.
interface regfile_rat_if #(
  parameter int NAME_W = 5,
  parameter int DATA_W = 32,
  parameter int NICK_W = 4,
  parameter int OP_W   = 6,
  parameter int IMM_W  = 32
);
  logic              iIND_en;
  logic [NAME_W-1:0] iIND_rs1_regnm;
  logic [NAME_W-1:0] iIND_rs2_regnm;
  logic [NAME_W-1:0] iIND_rd_regnm;
  logic [OP_W-1:0]   iIND_op;
  logic [31:0]       iIND_pc;
  logic [IMM_W-1:0]  iIND_imm;
  logic              iIND_pd;
  logic              oIND_stall;

  logic              iDP_stall;
  logic              oDP_en;
  logic [DATA_W-1:0] oDP_rs1_dt;
  logic [DATA_W-1:0] oDP_rs2_dt;
  logic [NICK_W-1:0] oDP_rs1_nick;
  logic [NICK_W-1:0] oDP_rs2_nick;
  logic [NAME_W-1:0] oDP_rd_regnm;
  logic [OP_W-1:0]   oDP_op;
  logic [31:0]       oDP_pc;
  logic [IMM_W-1:0]  oDP_imm;
  logic              oDP_pd;

  logic              iROB_nick_en;
  logic [NAME_W-1:0] iROB_nick_regnm;
  logic [NICK_W-1:0] iROB_nick;
  logic              iROB_en;
  logic [NAME_W-1:0] iROB_rd_regnm;
  logic [DATA_W-1:0] iROB_rd_dt;
  logic [NICK_W-1:0] iROB_rd_nick;

  modport master (
    output iIND_en, iIND_rs1_regnm, iIND_rs2_regnm,
    output iIND_rd_regnm, iIND_op, iIND_pc, iIND_imm,
    output iIND_pd, iDP_stall,
    output iROB_nick_en, iROB_nick_regnm, iROB_nick,
    output iROB_en, iROB_rd_regnm, iROB_rd_dt,
    output iROB_rd_nick,
    input  oIND_stall, oDP_en, oDP_rs1_dt, oDP_rs2_dt,
    input  oDP_rs1_nick, oDP_rs2_nick, oDP_rd_regnm,
    input  oDP_op, oDP_pc, oDP_imm, oDP_pd
  );

  modport slave (
    input  iIND_en, iIND_rs1_regnm, iIND_rs2_regnm,
    input  iIND_rd_regnm, iIND_op, iIND_pc, iIND_imm,
    input  iIND_pd, iDP_stall,
    input  iROB_nick_en, iROB_nick_regnm, iROB_nick,
    input  iROB_en, iROB_rd_regnm, iROB_rd_dt,
    input  iROB_rd_nick,
    output oIND_stall, oDP_en, oDP_rs1_dt, oDP_rs2_dt,
    output oDP_rs1_nick, oDP_rs2_nick, oDP_rd_regnm,
    output oDP_op, oDP_pc, oDP_imm, oDP_pd
  );
endinterface

// File: rtl/regfile_rat.sv
// Architectural register file + rename tag table, registered dispatch slot.
// Ports: clk, rst (async high), rdy (global hold), clr (flush), bus (slave).
// Option: REGFILE_RAT_BYPASS_EN forwards a tag-clearing commit into the read.
module regfile_rat #(
  parameter int REG_NUM = 32,
  parameter int NAME_W  = 5,
  parameter int DATA_W  = 32,
  parameter int NICK_W  = 4,
  parameter int OP_W    = 6,
  parameter int IMM_W   = 32
) (
  input logic         clk,
  input logic         rst,
  input logic         rdy,
  input logic         clr,
  regfile_rat_if.slave bus
);

  typedef struct packed {
    logic              en;
    logic [DATA_W-1:0] rs1_dt;
    logic [NICK_W-1:0] rs1_nick;
    logic [DATA_W-1:0] rs2_dt;
    logic [NICK_W-1:0] rs2_nick;
    logic [NAME_W-1:0] rd;
    logic [OP_W-1:0]   op;
    logic [31:0]       pc;
    logic [IMM_W-1:0]  imm;
    logic              pd;
  } dp_t;

  logic [DATA_W-1:0] dt_q   [REG_NUM];
  logic [NICK_W-1:0] nick_q [REG_NUM];
  dp_t               dp_q, dp_d;

  logic              cmt_v, cmt_clr, ren_v;
  logic [NAME_W-1:0] rs1, rs2, cmt_rd;
  logic [DATA_W-1:0] rs1_dt, rs2_dt;
  logic [NICK_W-1:0] rs1_nk, rs2_nk;

  assign rs1     = bus.iIND_rs1_regnm;
  assign rs2     = bus.iIND_rs2_regnm;
  assign cmt_rd  = bus.iROB_rd_regnm;
  assign cmt_v   = bus.iROB_en && (cmt_rd != '0);
  // Tag only retires if no newer rename replaced it.
  assign cmt_clr = cmt_v && (nick_q[cmt_rd] == bus.iROB_rd_nick);
  assign ren_v   = bus.iROB_nick_en &&
                   (bus.iROB_nick_regnm != '0);

  always_comb begin
    rs1_dt = dt_q[rs1];
    rs1_nk = nick_q[rs1];
    rs2_dt = dt_q[rs2];
    rs2_nk = nick_q[rs2];
`ifdef REGFILE_RAT_BYPASS_EN
    if (cmt_clr && (cmt_rd == rs1)) begin
      rs1_dt = bus.iROB_rd_dt;
      rs1_nk = '0;
    end
    if (cmt_clr && (cmt_rd == rs2)) begin
      rs2_dt = bus.iROB_rd_dt;
      rs2_nk = '0;
    end
`endif
  end

  always_comb begin
    dp_d = dp_q;
    if (clr) begin
      dp_d = '0;
    end else if (!bus.iDP_stall) begin
      dp_d = '0;
      if (bus.iIND_en) begin
        dp_d.en       = 1'b1;
        dp_d.rs1_dt   = rs1_dt;
        dp_d.rs1_nick = rs1_nk;
        dp_d.rs2_dt   = rs2_dt;
        dp_d.rs2_nick = rs2_nk;
        dp_d.rd       = bus.iIND_rd_regnm;
        dp_d.op       = bus.iIND_op;
        dp_d.pc       = bus.iIND_pc;
        dp_d.imm      = bus.iIND_imm;
        dp_d.pd       = bus.iIND_pd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_q <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        dt_q[i]   <= '0;
        nick_q[i] <= '0;
      end
    end else if (rdy) begin
      dp_q <= dp_d;
      if (cmt_v)
        dt_q[cmt_rd] <= bus.iROB_rd_dt;
      if (clr) begin
        for (int i = 0; i < REG_NUM; i++)
          nick_q[i] <= '0;
      end else begin
        if (cmt_clr)
          nick_q[cmt_rd] <= '0;
        // Later assignment: rename beats a same-register commit.
        if (ren_v)
          nick_q[bus.iROB_nick_regnm] <= bus.iROB_nick;
      end
    end
  end

  assign bus.oIND_stall   = bus.iDP_stall;
  assign bus.oDP_en       = dp_q.en;
  assign bus.oDP_rs1_dt   = dp_q.rs1_dt;
  assign bus.oDP_rs1_nick = dp_q.rs1_nick;
  assign bus.oDP_rs2_dt   = dp_q.rs2_dt;
  assign bus.oDP_rs2_nick = dp_q.rs2_nick;
  assign bus.oDP_rd_regnm = dp_q.rd;
  assign bus.oDP_op       = dp_q.op;
  assign bus.oDP_pc       = dp_q.pc;
  assign bus.oDP_imm      = dp_q.imm;
  assign bus.oDP_pd       = dp_q.pd;

endmodule
